// File: rtl/weight_buffer_pkg.sv
// weight_buffer_pkg
//   Sizing constants shared with the CNN ALU (element width, matrix order and
//   the resulting weight-matrix width) plus the loader's state encoding.
package weight_buffer_pkg;

    localparam int MP_BITWIDTH     = 8;
    localparam int WEIGHT_SIZE     = 4;
    localparam int WEIGHT_MATRIX_W = MP_BITWIDTH * WEIGHT_SIZE * WEIGHT_SIZE;
    localparam int WORD_WIDTH      = 32;
    localparam int NUM_WORDS       = WEIGHT_MATRIX_W / WORD_WIDTH;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_SWAP = 2'd3;

    typedef enum logic [1:0] {
        S_FILL = ST_FILL,
        S_FULL = ST_FULL,
        S_PEND = ST_PEND,
        S_SWAP = ST_SWAP
    } wb_state_e;

endpackage

// File: rtl/weight_buffer.sv
// weight_buffer
//   Double-buffered weight loader feeding the CNN ALU. 32-bit load words are
//   packed top-down into a shadow bank; a commit copies the shadow bank into
//   the active bank that drives the ALU, so the ALU always sees a complete,
//   stable matrix while the next one is loading.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active low
//   wr_valid_i      load word offered
//   wr_ready_o      load word can be accepted this cycle
//   wr_data_i       load word
//   commit_i        request shadow->active swap
//   clear_i         discard shadow contents (priority over everything)
//   busy_i          ALU is executing; no swap while high
//   weight_matrix_o active bank to the ALU
//   active_valid_o  active bank holds a committed matrix
//   shadow_full_o   shadow bank complete
//   word_cnt_o      words currently in the shadow bank
//   err_o           one-cycle pulse: commit while shadow not full
module weight_buffer #(
    parameter int  MP_BITWIDTH = weight_buffer_pkg::MP_BITWIDTH,
    parameter int  WEIGHT_SIZE = weight_buffer_pkg::WEIGHT_SIZE,
    parameter int  WORD_WIDTH  = weight_buffer_pkg::WORD_WIDTH,
    localparam int WM_W        = MP_BITWIDTH * WEIGHT_SIZE * WEIGHT_SIZE,
    localparam int NUM_WORDS   = WM_W / WORD_WIDTH,
    localparam int CNT_W       = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  commit_i,
    input  logic                  clear_i,
    input  logic                  busy_i,
    output logic [WM_W-1:0]       weight_matrix_o,
    output logic                  active_valid_o,
    output logic                  shadow_full_o,
    output logic [CNT_W-1:0]      word_cnt_o,
    output logic                  err_o
);
    import weight_buffer_pkg::*;

    // Word k lives in bank[NUM_WORDS-1-k], so word 0 occupies the MSBs.
    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] bank_t;

    wb_state_e        state, state_d;
    bank_t            shadow, active;
    logic [CNT_W-1:0] word_cnt;
    logic             accept;
    logic             do_swap;
    logic             err_d;

    // Ready is held low while in reset so every output reads zero then.
    assign wr_ready_o = rst_i && (state == S_FILL) && !clear_i;
    assign accept     = wr_valid_i && wr_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_FILL;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        do_swap = 1'b0;
        err_d   = 1'b0;
        if (clear_i) begin
            state_d = S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (commit_i) err_d = 1'b1;
                    if (accept && word_cnt == CNT_W'(NUM_WORDS - 1)) state_d = S_FULL;
                end
                S_FULL: begin
                    if (commit_i) state_d = busy_i ? S_PEND : S_SWAP;
                end
                S_PEND: begin
                    if (!busy_i) state_d = S_SWAP;
                end
                S_SWAP: begin
                    // The ALU must never see its weights change mid-op: if busy
                    // rose since the swap was scheduled, fall back to waiting.
                    if (busy_i) begin
                        state_d = S_PEND;
                    end else begin
                        do_swap = 1'b1;
                        state_d = S_FILL;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow         <= '0;
            active         <= '0;
            word_cnt       <= '0;
            active_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            err_o <= err_d;
            if (clear_i) begin
                word_cnt <= '0;
            end else if (do_swap) begin
                active         <= shadow;
                active_valid_o <= 1'b1;
                word_cnt       <= '0;
            end else if (accept) begin
                for (int k = 0; k < NUM_WORDS; k++)
                    if (word_cnt == CNT_W'(k)) shadow[NUM_WORDS-1-k] <= wr_data_i;
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    assign weight_matrix_o = active;
    assign word_cnt_o      = word_cnt;
    assign shadow_full_o   = (word_cnt == CNT_W'(NUM_WORDS));

endmodule

// File: tb/tb_weight_buffer.sv
module tb_weight_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [31:0]  wr_data = '0;
    logic         commit = 1'b0;
    logic         clear = 1'b0;
    logic         busy = 1'b0;
    logic [127:0] wm;
    logic         av;
    logic         full;
    logic [2:0]   cnt;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_wm = '0;

    always #5 clk = ~clk;

    weight_buffer dut (
        .clk_i(clk), .rst_i(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .commit_i(commit), .clear_i(clear), .busy_i(busy),
        .weight_matrix_o(wm), .active_valid_o(av), .shadow_full_o(full),
        .word_cnt_o(cnt), .err_o(err)
    );

    // Reference model: the shadow bank is a queue of accepted words; a commit
    // on a full bank marks it committed, the swap is armed at the first edge
    // seen with busy low, and happens one edge later.
    logic [31:0]  m_words[$];
    bit           m_committed = 0, m_armed = 0, m_err = 0, m_valid = 0;
    logic [127:0] m_active = '0;

    function automatic logic [127:0] pack_words();
        logic [127:0] r = '0;
        for (int k = 0; k < m_words.size(); k++) r[127-32*k -: 32] = m_words[k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_words.delete(); m_committed = 0; m_armed = 0; m_err = 0;
            m_valid = 0; m_active = '0;
        end else if (clear) begin
            m_words.delete(); m_committed = 0; m_armed = 0; m_err = 0;
        end else begin
            m_err = commit && (m_words.size() < 4);
            if (m_armed) begin
                if (!busy) begin
                    m_active = pack_words(); m_valid = 1;
                    m_words.delete(); m_committed = 0;
                end
                m_armed = 0;
            end else if (m_committed) begin
                if (!busy) m_armed = 1;
            end else if (m_words.size() == 4) begin
                if (commit) begin m_committed = 1; m_armed = !busy; end
            end else if (wr_valid) begin
                m_words.push_back(wr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_word(input logic [31:0] d);
        bit got = 0;
        wr_valid = 1'b1; wr_data = d; #1;
        for (int t = 0; t < 20 && !got; t++) begin
            if (wr_ready) got = 1;
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL load_word timeout: word %h never accepted", d);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (wm !== '0) begin errors++; $display("FAIL reset_wm got %h want 0", wm); end
        checks++; if (av !== 1'b0) begin errors++; $display("FAIL reset_av got %b want 0", av); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", wr_ready); end
        #3 rst_n = 1'b1; #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release got %b want 1", wr_ready); end
    endtask

    task automatic test_basic_load();
        load_word(32'h01020304); load_word(32'h05060708);
        load_word(32'h090A0B0C); load_word(32'h0D0E0F10);
        checks++; if (full !== 1'b1 || cnt !== 3'd4) begin errors++; $display("FAIL basic_full got full=%b cnt=%0d want 1/4", full, cnt); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full got %b want 0", wr_ready); end
        commit = 1'b1; tick(); commit = 1'b0;
        checks++; if (wm !== 128'h0) begin errors++; $display("FAIL basic_wm_early got %h want 0", wm); end
        tick();
        exp_wm = 128'h0102030405060708090A0B0C0D0E0F10;
        checks++; if (wm !== exp_wm) begin errors++; $display("FAIL basic_wm got %h want %h", wm, exp_wm); end
        checks++; if (av !== 1'b1 || cnt !== 3'd0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL basic_post got av=%b cnt=%0d ready=%b want 1/0/1", av, cnt, wr_ready); end
    endtask

    task automatic test_err();
        load_word(32'hAAAA0001); load_word(32'hAAAA0002);
        checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL err_cnt_before got %0d want 2", cnt); end
        commit = 1'b1; tick(); commit = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", err); end
        checks++; if (cnt !== 3'd2 || wm !== exp_wm) begin errors++; $display("FAIL err_state got cnt=%0d wm=%h want 2/%h", cnt, wm, exp_wm); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width got %b want 0", err); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL err_clear got %0d want 0", cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[7];
        for (int i = 0; i < 7; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) load_word(w[i]);
        wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
        tick(); tick();
        checks++; if (wr_ready !== 1'b0 || cnt !== 3'd4) begin errors++; $display("FAIL bp_hold got ready=%b cnt=%0d want 0/4", wr_ready, cnt); end
        commit = 1'b1; tick(); commit = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_swap_ready got %b want 0", wr_ready); end
        tick();
        exp_wm = {w[0], w[1], w[2], w[3]};
        checks++; if (wm !== exp_wm) begin errors++; $display("FAIL bp_wm1 got %h want %h", wm, exp_wm); end
        tick(); wr_valid = 1'b0;
        checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL bp_accept got cnt=%0d want 1", cnt); end
        for (int i = 4; i < 7; i++) load_word(w[i]);
        commit = 1'b1; tick(); commit = 1'b0; tick();
        exp_wm = {32'hDEADBEEF, w[4], w[5], w[6]};
        checks++; if (wm !== exp_wm) begin errors++; $display("FAIL bp_wm2 got %h want %h", wm, exp_wm); end
    endtask

    task automatic test_busy_pend();
        logic [127:0] nxt;
        nxt = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) load_word(nxt[127-32*i -: 32]);
        busy = 1'b1; commit = 1'b1; tick(); commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wm !== exp_wm) begin errors++; $display("FAIL pend_hold[%0d] got %h want %h", i, wm, exp_wm); end
        end
        busy = 1'b0; tick();
        checks++; if (wm !== exp_wm) begin errors++; $display("FAIL pend_edge got %h want %h", wm, exp_wm); end
        tick();
        exp_wm = nxt;
        checks++; if (wm !== exp_wm) begin errors++; $display("FAIL pend_swap got %h want %h", wm, exp_wm); end
    endtask

    task automatic test_clear_pend();
        for (int i = 0; i < 4; i++) load_word($urandom);
        busy = 1'b1; commit = 1'b1; tick(); commit = 1'b0; tick();
        clear = 1'b1; #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", wr_ready); end
        tick(); clear = 1'b0; #1;
        checks++; if (cnt !== 3'd0 || full !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL clr_state got cnt=%0d full=%b ready=%b want 0/0/1", cnt, full, wr_ready); end
        busy = 1'b0; tick(); tick(); tick();
        checks++; if (wm !== exp_wm || av !== 1'b1) begin errors++; $display("FAIL clr_active got %h av=%b want %h", wm, av, exp_wm); end
    endtask

    task automatic test_async_reset();
        logic [127:0] nxt;
        for (int i = 0; i < 3; i++) load_word($urandom);
        #2 rst_n = 1'b0; #1;
        checks++; if (wm !== '0 || av !== 1'b0 || cnt !== 3'd0 || full !== 1'b0 || err !== 1'b0 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL arst got wm=%h av=%b cnt=%0d full=%b err=%b ready=%b want all 0", wm, av, cnt, full, err, wr_ready); end
        #2 rst_n = 1'b1;
        tick();
        nxt = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) load_word(nxt[127-32*i -: 32]);
        commit = 1'b1; tick(); commit = 1'b0; tick();
        exp_wm = nxt;
        checks++; if (wm !== exp_wm || av !== 1'b1) begin errors++; $display("FAIL arst_reload got %h av=%b want %h", wm, av, exp_wm); end
    endtask

    task automatic test_random();
        bit taken = 1;
        bit exp_ready;
        for (int i = 0; i < 800; i++) begin
            if (!wr_valid || taken) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data  = $urandom;
            end
            commit = ($urandom_range(0, 5) == 0);
            clear  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) busy = ~busy;
            #1;
            exp_ready = rst_n && !clear && (m_words.size() < 4) && !m_committed;
            checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, wr_ready, exp_ready); end
            taken = wr_valid && wr_ready;
            @(posedge clk); #1;
            checks++;
            if (wm !== m_active || av !== m_valid || cnt !== 3'(m_words.size()) ||
                full !== (m_words.size() == 4) || err !== m_err) begin
                errors++;
                $display("FAIL rnd_out[%0d] got wm=%h av=%b cnt=%0d full=%b err=%b want wm=%h av=%b cnt=%0d err=%b",
                         i, wm, av, cnt, full, err, m_active, m_valid, m_words.size(), m_err);
            end
        end
        wr_valid = 1'b0; commit = 1'b0; clear = 1'b0; busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_err();
        test_backpressure();
        test_busy_pend();
        test_clear_pend();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_buffer.md
Name: weight_buffer

Overview:
- Sequential loader that sits directly upstream of the CNN-capable ALU and drives its 128-bit weight_matrix input.
- Accepts 32-bit words from the register-file write path and assembles them in a shadow bank.
- On commit, swaps the shadow bank into an active bank, so the ALU always sees a stable, complete weight matrix while the next one loads.

Parameters:
- MP_BITWIDTH, 8, bits per weight element
- WEIGHT_SIZE, 4, matrix is WEIGHT_SIZE x WEIGHT_SIZE elements
- WORD_WIDTH, 32, bits per load word
- NUM_WORDS, MP_BITWIDTH*WEIGHT_SIZE*WEIGHT_SIZE/WORD_WIDTH (=4), derived; words per matrix (must be an integer)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- wr_valid_i  in  1  load word offered
- wr_ready_o  out  1  buffer can accept a word this cycle
- wr_data_i  in  WORD_WIDTH  load word
- commit_i  in  1  request shadow->active swap (single-cycle pulse)
- clear_i  in  1  discard the partially or fully loaded shadow bank
- busy_i  in  1  ALU is executing an FC/Conv2d op; a swap must not occur while high
- weight_matrix_o  out  MP_BITWIDTH*WEIGHT_SIZE*WEIGHT_SIZE  active bank, connects to ALU weight_matrix
- active_valid_o  out  1  active bank holds at least one committed matrix
- shadow_full_o  out  1  shadow bank complete
- word_cnt_o  out  $clog2(NUM_WORDS+1)  words currently in the shadow bank
- err_o  out  1  one-cycle pulse when commit_i arrives while shadow is not full

Behaviour:
- Reset (rst_i=0, async): shadow=0, active=0, word_cnt=0, state=FILL, active_valid_o=0, err_o=0, wr_ready_o=1 once released.
- Handshake: a word transfers on an edge where wr_valid_i & wr_ready_o. wr_ready_o=1 only in FILL and when clear_i=0.
- Packing: the k-th word (k=0..NUM_WORDS-1) goes to shadow[TOP-k*WORD_WIDTH -: WORD_WIDTH], with TOP=MSB. Word 0 therefore lands in [127:96], matching the ALU's top-down slicing of FC and Conv2d weights.
- States:
  - FILL: accept words, word_cnt++. When the accepted word makes word_cnt==NUM_WORDS, go to FULL.
  - FULL: wr_ready_o=0. On commit_i with busy_i=0, go to SWAP. On commit_i with busy_i=1, go to PEND.
  - PEND: wait. When busy_i=0, go to SWAP.
  - SWAP: single cycle. active<=shadow, active_valid_o<=1, word_cnt<=0, go to FILL. The shadow contents are retained but overwritten by the next loads.
- Latency:
  - Commit at edge N with busy_i=0 -> FULL->SWAP at N; weight_matrix_o changes at edge N+1; wr_ready_o=1 in the cycle after N+1.
  - In PEND, the swap edge is the first edge with busy_i=0 plus one.
- weight_matrix_o changes only on the SWAP edge, never while busy_i=1.
- clear_i has priority over commit_i and writes. In any state it zeroes word_cnt and returns to FILL. This includes PEND, which cancels the pending swap. The active bank is untouched.
- commit_i in FILL: no state change; err_o pulses high for exactly one cycle.
- commit_i in PEND or SWAP: ignored, no error.
- wr_valid_i while wr_ready_o=0: word is not taken; the source must hold it (valid/data stable until ready).
- Reset mid-load or mid-PEND: everything returns to reset values immediately; any partial matrix is lost.
- No arithmetic beyond the counter; the counter never exceeds NUM_WORDS.

Decomposition:
- Shared package/header with the CNN sizing constants also used by the ALU: MP_BITWIDTH, WEIGHT_SIZE, and the weight-matrix width. Also the FILL/FULL/PEND/SWAP state encoding (2-bit localparams).
- No sub-module needed. The shadow/active register pair plus the FSM form one block; a separate bank-register module is not warranted.

Test Plan:
- Reset, then load 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 with busy_i=0, then commit -> weight_matrix_o=0x0102...0F10 one edge after the commit edge; active_valid_o=1; word_cnt_o=0; wr_ready_o=1.
- Load 4 words, hold wr_valid_i with a 5th word 0xDEADBEEF -> wr_ready_o=0 and the 5th word is not accepted. After commit, it is accepted as word 0 of the next matrix (bits [127:96]).
- Load 4 words, commit while busy_i=1 for 3 cycles -> weight_matrix_o holds its previous value throughout; it updates one edge after busy_i falls.
- Load 2 words, pulse commit_i -> err_o high for exactly 1 cycle; word_cnt_o stays 2; active unchanged.
- In PEND, assert clear_i -> state FILL, word_cnt_o=0; the active bank keeps the old matrix after busy_i falls.
- Assert rst_i=0 asynchronously (between edges) after 3 words -> all outputs 0 immediately; the next load starts at word 0.
